// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: hazard FSM states,
// register-number type, and the bundle of latch enable/flush controls.
package cpu_types_pkg;

  // Register-file index (MIPS has 32 architectural registers)
  typedef logic [4:0] regbits_t;

  // Hazard controller states: normal run, waiting on the dcache, frozen by halt
  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_DWAIT = 2'b01,
    HZ_HALT  = 2'b10
  } hz_state_t;

  // One load-enable / bubble-insert pair per pipeline latch, PC has enable only
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } hz_ctrl_t;

  // Everything advances, nothing is squashed
  localparam hz_ctrl_t HZ_CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
    idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, exmem_flush: 1'b0,
    memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // Whole pipeline frozen
  localparam hz_ctrl_t HZ_CTRL_FREEZE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
    idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, exmem_flush: 1'b0,
    memwb_en: 1'b0, memwb_flush: 1'b0
  };

  // Dcache miss: front of the pipe holds, MEM/WB takes a bubble so the
  // instruction already in WB is not written back a second time
  localparam hz_ctrl_t HZ_CTRL_DSTALL = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
    idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, exmem_flush: 1'b0,
    memwb_en: 1'b1, memwb_flush: 1'b1
  };

  // Redirect resolved in MEM: PC takes the target, the three younger
  // latches are squashed, the redirecting instruction moves on to WB
  localparam hz_ctrl_t HZ_CTRL_REDIRECT = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
    idex_en: 1'b1, idex_flush: 1'b1,
    exmem_en: 1'b1, exmem_flush: 1'b1,
    memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // Load-use: consumer waits one cycle in IF/ID, a bubble goes into EX
  localparam hz_ctrl_t HZ_CTRL_LOADUSE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
    idex_en: 1'b1, idex_flush: 1'b1,
    exmem_en: 1'b1, exmem_flush: 1'b0,
    memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // Icache miss: PC retries the fetch, a bubble goes into decode
  localparam hz_ctrl_t HZ_CTRL_IMISS = '{
    pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1,
    idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, exmem_flush: 1'b0,
    memwb_en: 1'b1, memwb_flush: 1'b0
  };

  // A load in EX whose destination feeds the instruction in decode.
  // Register 0 is hard-wired, so a "write" to it never creates a hazard.
  function automatic logic hz_load_use(input logic     idex_dren,
                                       input regbits_t idex_rt,
                                       input regbits_t ifid_rs,
                                       input regbits_t ifid_rt);
    return idex_dren && (idex_rt != '0) &&
           ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Sticks at all-ones instead of wrapping so a long run never reads as short.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == {W{1'b1}});

  // Count enabled events, clear has priority, hold once saturated
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Central stall/flush controller for the 5-stage pipeline. Decides, each
// cycle, which latches load and which take a bubble, from cache handshakes,
// load-use hazards, MEM-stage redirects and halt reaching writeback.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_redirect,
  input  logic             idex_dREN,
  input  regbits_t         idex_rt,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t r_state;
  hz_state_t w_state_next;

  logic     w_mem_req;
  logic     w_mem_stall;
  logic     w_load_use;
  logic     w_redirect_fire;
  logic     w_halted;
  logic     w_stall_inc;
  hz_ctrl_t w_ctrl;

  assign w_mem_req   = exmem_dREN | exmem_dWEN;
  assign w_mem_stall = w_mem_req & ~dhit;
  assign w_load_use  = hz_load_use(idex_dREN, idex_rt, ifid_rs, ifid_rt);

  // Next state: enter DWAIT on an outstanding data access, leave on dhit;
  // halt in writeback overrides everything and only reset leaves HALT
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      HZ_RUN:   if (w_mem_stall) w_state_next = HZ_DWAIT;
      HZ_DWAIT: if (dhit)        w_state_next = HZ_RUN;
      HZ_HALT:                   w_state_next = HZ_HALT;
      default:                   w_state_next = HZ_RUN;
    endcase
    if (memwb_halt) begin
      w_state_next = HZ_HALT;
    end
  end

  // State register, asynchronously returned to RUN by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority decode of the latch controls; depends only on inputs and state
  always_comb begin
    w_ctrl          = HZ_CTRL_ADVANCE;
    w_halted        = 1'b0;
    w_redirect_fire = 1'b0;
    if (r_state == HZ_HALT) begin
      w_ctrl   = HZ_CTRL_FREEZE;
      w_halted = 1'b1;
    end else if (w_mem_stall) begin
      w_ctrl = HZ_CTRL_DSTALL;
    end else if (exmem_redirect) begin
      w_ctrl          = HZ_CTRL_REDIRECT;
      w_redirect_fire = 1'b1;
    end else if (w_load_use) begin
      w_ctrl = HZ_CTRL_LOADUSE;
    end else if (!ihit) begin
      w_ctrl = HZ_CTRL_IMISS;
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign ifid_en     = w_ctrl.ifid_en;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_en     = w_ctrl.idex_en;
  assign idex_flush  = w_ctrl.idex_flush;
  assign exmem_en    = w_ctrl.exmem_en;
  assign exmem_flush = w_ctrl.exmem_flush;
  assign memwb_en    = w_ctrl.memwb_en;
  assign memwb_flush = w_ctrl.memwb_flush;
  assign halted      = w_halted;

  // Halt freezes the PC on purpose, so it is not counted as a stall
  assign w_stall_inc = ~w_ctrl.pc_en & (r_state != HZ_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_inc   (w_stall_inc),
    .i_clr   (1'b0),
    .o_count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .i_inc   (w_redirect_fire),
    .i_clr   (1'b0),
    .o_count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a table of single-cycle decode
// vectors followed by hand-written multi-cycle sequences (dcache wait,
// redirect counting, halt freeze with async reset, counter saturation).
module tb_hazard_unit;
  import cpu_types_pkg::*;

  localparam int CNT_W = 16;

  // Expected control words {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb_en,memwb_fl}
  localparam logic [8:0] E_ADV  = 9'b1_10_10_10_10;
  localparam logic [8:0] E_DST  = 9'b0_00_00_00_11;
  localparam logic [8:0] E_RED  = 9'b1_11_11_11_10;
  localparam logic [8:0] E_LU   = 9'b0_00_11_10_10;
  localparam logic [8:0] E_IM   = 9'b0_11_10_10_10;
  localparam logic [8:0] E_FRZ  = 9'b0_00_00_00_00;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect;
  logic             idex_dREN, memwb_halt;
  regbits_t         idex_rt, ifid_rs, ifid_rt;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0]       ctrlBus;

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       redirect;
    logic       idexDren;
    logic [4:0] idexRt;
    logic [4:0] ifidRs;
    logic [4:0] ifidRt;
    logic [8:0] expCtrl;
  } vec_t;

  vec_t vecs[15];

  always #5 CLK = ~CLK;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .dhit           (dhit),
    .exmem_dREN     (exmem_dREN),
    .exmem_dWEN     (exmem_dWEN),
    .exmem_redirect (exmem_redirect),
    .idex_dREN      (idex_dREN),
    .idex_rt        (idex_rt),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .memwb_halt     (memwb_halt),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_en        (idex_en),
    .idex_flush     (idex_flush),
    .exmem_en       (exmem_en),
    .exmem_flush    (exmem_flush),
    .memwb_en       (memwb_en),
    .memwb_flush    (memwb_flush),
    .halted         (halted),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign ctrlBus = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, memwb_flush};

  function automatic vec_t mkVec(input logic ih, input logic dh, input logic dr,
                                 input logic dw, input logic rd, input logic ld,
                                 input logic [4:0] rt, input logic [4:0] rs,
                                 input logic [4:0] rt2, input logic [8:0] exp);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.redirect = rd;
    v.idexDren = ld; v.idexRt = rt; v.ifidRs = rs; v.ifidRt = rt2;
    v.expCtrl = exp;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ihit           = v.ihit;
    dhit           = v.dhit;
    exmem_dREN     = v.dren;
    exmem_dWEN     = v.dwen;
    exmem_redirect = v.redirect;
    idex_dREN      = v.idexDren;
    idex_rt        = v.idexRt;
    ifid_rs        = v.ifidRs;
    ifid_rt        = v.ifidRt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic pulseReset();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    // ih dh dr dw rd ld rt rs rt2 expected
    vecs[0]  = mkVec(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_ADV);
    vecs[1]  = mkVec(1, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd1, E_LU);
    vecs[2]  = mkVec(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, E_ADV);
    vecs[3]  = mkVec(1, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, E_LU);
    vecs[4]  = mkVec(1, 0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, E_ADV);
    vecs[5]  = mkVec(1, 0, 0, 0, 0, 1, 5'd7, 5'd8, 5'd9, E_ADV);
    vecs[6]  = mkVec(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_IM);
    vecs[7]  = mkVec(0, 0, 0, 0, 0, 1, 5'd12, 5'd12, 5'd0, E_LU);
    vecs[8]  = mkVec(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, E_RED);
    vecs[9]  = mkVec(1, 0, 0, 0, 1, 1, 5'd4, 5'd4, 5'd4, E_RED);
    vecs[10] = mkVec(1, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, E_DST);
    vecs[11] = mkVec(1, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, E_ADV);
    vecs[12] = mkVec(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_IM);
    vecs[13] = mkVec(1, 0, 1, 0, 0, 1, 5'd9, 5'd9, 5'd0, E_DST);
    vecs[14] = mkVec(1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, E_ADV);

    applyStimulus(vecs[0]);
    memwb_halt = 1'b0;

    // Reset values, checked while reset is held
    #12;
    checkOutput("rst_ctrl", {22'd0, ctrlBus, halted}, {22'd0, E_ADV, 1'b0});
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("post_rst_ctrl", 32'(ctrlBus), 32'(E_ADV));
    checkOutput("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Single-cycle decode table
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), {22'd0, ctrlBus, halted},
                  {22'd0, vecs[i].expCtrl, 1'b0});
    end

    @(negedge CLK);
    applyStimulus(vecs[0]);
    pulseReset();

    // Dcache wait: three miss cycles then the hit
    @(negedge CLK);
    exmem_dREN = 1'b1;
    dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("dwait_ctrl%0d", i), 32'(ctrlBus), 32'(E_DST));
      @(posedge CLK);
      #1;
      checkOutput($sformatf("dwait_state%0d", i), 32'(dut.r_state), 32'(HZ_DWAIT));
      @(negedge CLK);
    end
    dhit = 1'b1;
    #1;
    checkOutput("dhit_ctrl", 32'(ctrlBus), 32'(E_ADV));
    @(posedge CLK);
    #1;
    checkOutput("dhit_state", 32'(dut.r_state), 32'(HZ_RUN));
    checkOutput("dwait_stall_cnt", 32'(stall_cnt), 32'd3);

    // Redirect while the icache misses
    @(negedge CLK);
    exmem_dREN = 1'b0;
    dhit = 1'b0;
    ihit = 1'b0;
    exmem_redirect = 1'b1;
    #1;
    checkOutput("redir_ctrl", 32'(ctrlBus), 32'(E_RED));
    checkOutput("redir_flush_pre", 32'(flush_cnt), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("redir_flush_post", 32'(flush_cnt), 32'd1);
    checkOutput("redir_stall_cnt", 32'(stall_cnt), 32'd3);

    // Halt arriving in WB during a redirect
    @(negedge CLK);
    ihit = 1'b1;
    memwb_halt = 1'b1;
    #1;
    checkOutput("halt_entry_ctrl", {22'd0, ctrlBus, halted}, {22'd0, E_RED, 1'b0});
    @(posedge CLK);
    #1;
    checkOutput("halt_flush_cnt", 32'(flush_cnt), 32'd2);
    @(negedge CLK);
    memwb_halt = 1'b0;
    exmem_redirect = 1'b0;
    ihit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("halt_hold%0d", i), {22'd0, ctrlBus, halted},
                  {22'd0, E_FRZ, 1'b1});
      checkOutput($sformatf("halt_stall%0d", i), 32'(stall_cnt), 32'd3);
      @(negedge CLK);
    end
    nRST = 1'b0;
    #1;
    checkOutput("halt_rst_state", 32'(dut.r_state), 32'(HZ_RUN));
    checkOutput("halt_rst_halted", 32'(halted), 32'd0);
    checkOutput("halt_rst_stall", 32'(stall_cnt), 32'd0);
    checkOutput("halt_rst_flush", 32'(flush_cnt), 32'd0);
    #1;
    nRST = 1'b1;
    ihit = 1'b1;
    #1;
    checkOutput("after_halt_ctrl", 32'(ctrlBus), 32'(E_ADV));

    // Stall counter saturation
    @(negedge CLK);
    ihit = 1'b0;
    #1;
    checkOutput("sat_ctrl", 32'(ctrlBus), 32'(E_IM));
    for (int i = 0; i < 65534; i++) begin
      @(posedge CLK);
    end
    #1;
    checkOutput("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("sat_ffff%0d", i), 32'(stall_cnt), 32'h0000_FFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
